// File: rtl/fb_fetch_pkg.sv
// Shared constants and types for the framebuffer scan-out DMA.
package fb_fetch_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int unsigned FIFO_DEPTH_LOG2_DEF = 5;
    localparam int unsigned BURST_LEN_LOG2_DEF  = 2;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StBurst
    } state_e;

endpackage

// File: rtl/fb_fetch_fifo.sv
// Synchronous show-ahead FIFO with occupancy output for the fetch space check.
module fb_fetch_fifo
    import fb_fetch_pkg::*;
#(
    parameter int unsigned depth_log2 = FIFO_DEPTH_LOG2_DEF
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  wr_en,
    input  logic [31:0]           wr_dat,
    input  logic                  rd_en,
    output logic [31:0]           rd_dat,
    output logic                  valid,
    output logic [depth_log2:0]   level
);

    localparam int unsigned Depth = 1 << depth_log2;
    localparam logic [depth_log2:0] FullLvl = (depth_log2 + 1)'(Depth);

    logic [31:0]           mem_q [Depth];
    logic [depth_log2-1:0] wr_ptr_q;
    logic [depth_log2-1:0] rd_ptr_q;
    logic [depth_log2:0]   count_q;
    logic                  do_rd;

    assign do_rd  = rd_en && (count_q != '0);
    assign valid  = (count_q != '0);
    assign level  = count_q;
    assign rd_dat = mem_q[rd_ptr_q];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (wr_en && !do_rd) begin
                count_q <= count_q + 1'b1;
            end else if (!wr_en && do_rd) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_dat;
        end
    end

    // The fetcher only starts a burst when the whole burst fits.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst && wr_en) begin
            assert (count_q != FullLvl);
        end
    end

endmodule

// File: rtl/fb_fetch.sv
// Framebuffer scan-out DMA: Wishbone burst reader feeding a show-ahead pixel FIFO.
// Optional sticky underrun flag enabled by defining FB_FETCH_UNDERRUN_EN.
module fb_fetch
    import fb_fetch_pkg::*;
#(
    parameter int unsigned fifo_depth_log2 = FIFO_DEPTH_LOG2_DEF,
    parameter int unsigned burst_len_log2  = BURST_LEN_LOG2_DEF
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic [31:0] frame_base,
    input  logic [23:0] frame_words,
    output logic        busy,
    output logic        done,
    output logic [31:0] m_adr_o,
    output logic [2:0]  m_cti_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_dat_o,
    output logic        m_we_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,
    output logic [31:0] pix_dat,
    output logic        pix_valid,
    input  logic        pix_rd,
    output logic        underrun
);

    localparam int unsigned CntW = 24 - burst_len_log2;
    localparam int unsigned LvlW = fifo_depth_log2 + 1;
    localparam logic [LvlW-1:0]           DepthLvl = LvlW'(1 << fifo_depth_log2);
    localparam logic [LvlW-1:0]           BurstLvl = LvlW'(1 << burst_len_log2);
    localparam logic [burst_len_log2-1:0] LastBeat = '1;

    state_e                    state_q, state_d;
    logic [31:0]               adr_q, adr_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [burst_len_log2-1:0] beat_q, beat_d;
    logic                      cyc_q, cyc_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic                      ack;
    logic                      pop;
    logic                      start_ok;
    logic [LvlW-1:0]           level;
    logic [LvlW-1:0]           space;
    logic [CntW-1:0]           start_cnt;
    logic                      unused_addr_bits;

    assign unused_addr_bits = ^{frame_base[1:0], frame_words[burst_len_log2-1:0]};

    assign ack       = m_ack_i && cyc_q;
    assign pop       = pix_rd && pix_valid;
    assign start_ok  = start && (state_q == StIdle);
    assign start_cnt = frame_words[23:burst_len_log2];
    // A same-cycle pop frees a slot in time for the first beat.
    assign space     = DepthLvl - level + {{(LvlW-1){1'b0}}, pop};

    fb_fetch_fifo #(
        .depth_log2 (fifo_depth_log2)
    ) u_fifo (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .wr_en   (ack),
        .wr_dat  (m_dat_i),
        .rd_en   (pix_rd),
        .rd_dat  (pix_dat),
        .valid   (pix_valid),
        .level   (level)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= StIdle;
            adr_q   <= '0;
            cnt_q   <= '0;
            beat_q  <= '0;
            cyc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            cyc_q   <= cyc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        cyc_d   = cyc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    adr_d  = {frame_base[31:2], 2'b00};
                    cnt_d  = start_cnt;
                    beat_d = '0;
                    if (start_cnt == '0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (space >= BurstLvl) begin
                    state_d = StBurst;
                    cyc_d   = 1'b1;
                end
            end
            StBurst: begin
                if (ack) begin
                    adr_d  = adr_q + 32'd4;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LastBeat) begin
                        cyc_d = 1'b0;
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == CntW'(1)) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = StIdle;
                        end else begin
                            state_d = StWait;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        m_cyc_o = cyc_q;
        m_stb_o = cyc_q;
        m_adr_o = adr_q;
        m_sel_o = 4'hf;
        m_dat_o = '0;
        m_we_o  = 1'b0;
        m_cti_o = CTI_CLASSIC;
        if (cyc_q) begin
            m_cti_o = (beat_q == LastBeat) ? CTI_EOB : CTI_INCR;
        end
        busy = busy_q;
        done = done_q;
    end

`ifdef FB_FETCH_UNDERRUN_EN
    logic underrun_q, underrun_d;

    always_comb begin
        underrun_d = underrun_q;
        if (start_ok) begin
            underrun_d = 1'b0;
        end else if (busy_q && pix_rd && !pix_valid) begin
            underrun_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= underrun_d;
        end
    end

    assign underrun = underrun_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
    assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_fb_fetch.sv
// Self-checking bench for fb_fetch: table-driven and random frames against a queue model.
module tb_fb_fetch;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        start;
    logic [31:0] frame_base;
    logic [23:0] frame_words;
    logic        busy, done;
    logic [31:0] m_adr_o, m_dat_o, m_dat_i;
    logic [2:0]  m_cti_o;
    logic [3:0]  m_sel_o;
    logic        m_we_o, m_cyc_o, m_stb_o, m_ack_i;
    logic [31:0] pix_dat;
    logic        pix_valid, pix_rd, underrun;

    always #5 sys_clk = ~sys_clk;

    fb_fetch dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .start       (start),
        .frame_base  (frame_base),
        .frame_words (frame_words),
        .busy        (busy),
        .done        (done),
        .m_adr_o     (m_adr_o),
        .m_cti_o     (m_cti_o),
        .m_sel_o     (m_sel_o),
        .m_dat_o     (m_dat_o),
        .m_we_o      (m_we_o),
        .m_cyc_o     (m_cyc_o),
        .m_stb_o     (m_stb_o),
        .m_dat_i     (m_dat_i),
        .m_ack_i     (m_ack_i),
        .pix_dat     (pix_dat),
        .pix_valid   (pix_valid),
        .pix_rd      (pix_rd),
        .underrun    (underrun)
    );

    int checks = 0;
    int errors = 0;
    int ws     = 0;
    int rd_pct = 0;
    int wcnt   = 0;
    int done_cnt = 0;
    int gap_viol = 0;
    int und_seen = 0;
    logic eob_prev = 1'b0;
    logic [31:0] beat_adr[$];
    logic [2:0]  beat_cti[$];
    logic [31:0] pix_q[$];

    typedef struct {
        logic [31:0] base;
        logic [23:0] words;
        int          wstates;
        int          rd;
        int          beats;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0F0F_3C3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Wishbone slave with programmable wait states, pixel consumer and event monitor.
    initial begin
        m_ack_i = 1'b0;
        m_dat_i = '0;
        pix_rd  = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (eob_prev && m_cyc_o) gap_viol++;
            eob_prev = 1'b0;
            if (done) done_cnt++;
            if (underrun) und_seen++;
            if (m_cyc_o && m_stb_o) begin
                if (wcnt >= ws) begin
                    m_ack_i = 1'b1;
                    m_dat_i = mem_word(m_adr_o);
                    beat_adr.push_back(m_adr_o);
                    beat_cti.push_back(m_cti_o);
                    eob_prev = (m_cti_o == 3'b111);
                    wcnt = 0;
                end else begin
                    m_ack_i = 1'b0;
                    wcnt++;
                end
            end else begin
                m_ack_i = 1'b0;
                wcnt = 0;
            end
            pix_rd = ($urandom_range(99) < rd_pct);
            if (pix_rd && pix_valid) pix_q.push_back(pix_dat);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_log;
        beat_adr.delete();
        beat_cti.delete();
        pix_q.delete();
        done_cnt = 0;
        gap_viol = 0;
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [23:0] w);
        @(negedge sys_clk);
        frame_base  = b;
        frame_words = w;
        start       = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        chk("done_seen", 32'(done_cnt != 0), 32'd1);
    endtask

    task automatic drain(input int budget);
        int idle = 0;
        int n = 0;
        rd_pct = 100;
        while (idle < 4 && n < budget) begin
            @(negedge sys_clk);
            n++;
            if (!pix_valid && !busy) idle++;
            else idle = 0;
        end
        chk("drain_empty", 32'(pix_valid), 32'd0);
    endtask

    task automatic check_frame(input logic [31:0] b, input int nbeats, input string tag);
        logic [31:0] base_al;
        logic [31:0] ea;
        base_al = {b[31:2], 2'b00};
        chk({tag, "_beats"}, 32'(beat_adr.size()), 32'(nbeats));
        chk({tag, "_words"}, 32'(pix_q.size()), 32'(nbeats));
        for (int i = 0; i < nbeats; i++) begin
            ea = base_al + 32'(4 * i);
            if (i < beat_adr.size()) begin
                chk({tag, "_adr"}, beat_adr[i], ea);
                chk({tag, "_cti"}, 32'(beat_cti[i]), 32'((i % 4 == 3) ? 3'b111 : 3'b010));
            end
            if (i < pix_q.size()) chk({tag, "_data"}, pix_q[i], mem_word(ea));
        end
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_cyc_gap"}, 32'(gap_viol), 32'd0);
    endtask

    task automatic run_frame(input logic [31:0] b, input logic [23:0] w, input int wsv,
                             input int rd, input int nbeats, input string tag);
        clear_log();
        ws     = wsv;
        rd_pct = rd;
        pulse_start(b, w);
        wait_done(5000);
        drain(3000);
        check_frame(b, nbeats, tag);
    endtask

    initial begin
        logic [31:0] rb;
        logic [23:0] rw;
        int n;

        vecs[0] = '{32'h4000_0010, 24'd16, 0, 100, 16};
        vecs[1] = '{32'h1234_567B, 24'd23, 1,  50, 20};
        vecs[2] = '{32'hFFFF_FFF0, 24'd12, 0,  70, 12};
        vecs[3] = '{32'h8000_0004, 24'd40, 2,  30, 40};
        vecs[4] = '{32'h0000_0100, 24'd7,  3, 100,  4};

        start = 1'b0;
        frame_base = '0;
        frame_words = '0;
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cyc", 32'(m_cyc_o), 32'd0);
        chk("rst_stb", 32'(m_stb_o), 32'd0);
        chk("rst_adr", m_adr_o, 32'd0);
        chk("rst_cti", 32'(m_cti_o), 32'd0);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        sys_rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].base, vecs[i].words, vecs[i].wstates, vecs[i].rd, vecs[i].beats,
                      "vec");
        end

        for (int r = 0; r < 6; r++) begin
            rb = $urandom;
            rw = 24'($urandom_range(60));
            run_frame(rb, rw, int'($urandom_range(2)), int'($urandom_range(100, 20)),
                      int'(rw / 4) * 4, "rand");
        end

        // Word count below one burst: immediate done, no bus activity.
        clear_log();
        @(negedge sys_clk);
        frame_base  = 32'h1111_0000;
        frame_words = 24'd3;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        chk("zero_done_pulse", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        @(negedge sys_clk);
        chk("zero_done_drop", 32'(done), 32'd0);
        repeat (5) @(negedge sys_clk);
        chk("zero_no_beats", 32'(beat_adr.size()), 32'd0);
        chk("zero_cyc", 32'(m_cyc_o), 32'd0);

        // Consumer stalled: fetch must stop with the FIFO full, then resume.
        clear_log();
        ws = 0;
        rd_pct = 0;
        pulse_start(32'h2000_0000, 24'd64);
        repeat (300) @(negedge sys_clk);
        chk("full_beats", 32'(beat_adr.size()), 32'd32);
        chk("full_cyc", 32'(m_cyc_o), 32'd0);
        chk("full_valid", 32'(pix_valid), 32'd1);
        chk("full_busy", 32'(busy), 32'd1);
        rd_pct = 100;
        wait_done(3000);
        drain(2000);
        check_frame(32'h2000_0000, 64, "full");

        // Second start mid-frame is ignored.
        clear_log();
        ws = 2;
        rd_pct = 80;
        pulse_start(32'h3000_0100, 24'd32);
        repeat (25) @(negedge sys_clk);
        pulse_start(32'h5555_0000, 24'd8);
        wait_done(3000);
        drain(2000);
        check_frame(32'h3000_0100, 32, "midstart");

        // Reset during the second beat of a burst.
        clear_log();
        ws = 2;
        rd_pct = 0;
        pulse_start(32'h6000_0000, 24'd16);
        n = 0;
        while (beat_adr.size() < 1 && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        chk("rst_reach_beat", 32'(beat_adr.size() >= 1), 32'd1);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        chk("midrst_cyc", 32'(m_cyc_o), 32'd0);
        chk("midrst_stb", 32'(m_stb_o), 32'd0);
        chk("midrst_valid", 32'(pix_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        sys_rst = 1'b0;
        run_frame(32'h7000_0040, 24'd20, 1, 100, 20, "postrst");

`ifdef FB_FETCH_UNDERRUN_EN
        clear_log();
        ws = 2;
        rd_pct = 100;
        pulse_start(32'h0900_0000, 24'd8);
        wait_done(2000);
        chk("und_set", 32'(underrun), 32'd1);
        drain(1000);
        chk("und_hold", 32'(underrun), 32'd1);
        check_frame(32'h0900_0000, 8, "und");
        clear_log();
        @(negedge sys_clk);
        frame_base  = 32'h0A00_0000;
        frame_words = 24'd4;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        chk("und_clr", 32'(underrun), 32'd0);
        wait_done(2000);
        drain(1000);
        check_frame(32'h0A00_0000, 4, "und2");
`else
        chk("underrun_tied", 32'(und_seen), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fb_fetch.md
Name: fb_fetch

Overview:
Framebuffer scan-out DMA. Acts as a Wishbone master feeding one master port of the system bus interconnect. Reads a frame of 32-bit words from memory using 4-beat incrementing bursts and buffers them in an internal FIFO. The downstream video/pixel output stage drains the FIFO through a valid/read handshake.

Parameters:
fifo_depth_log2, 5, FIFO depth is 2^fifo_depth_log2 words (32); must be >= 3.
burst_len_log2, 2, burst length is 2^burst_len_log2 beats (4).

Ports:
sys_clk  in  1  system clock; all logic is on the rising edge.
sys_rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse; begins a frame fetch.
frame_base  in  32  frame start byte address; bits [1:0] are ignored.
frame_words  in  24  number of 32-bit words to fetch; low burst_len_log2 bits are ignored.
busy  out  1  high while a frame fetch is in progress.
done  out  1  one-cycle pulse when the last word of the frame is written into the FIFO.
m_adr_o  out  32  Wishbone address, word aligned.
m_cti_o  out  3  3'b010 for incrementing beats, 3'b111 for the last beat of a burst.
m_sel_o  out  4  constant 4'hf.
m_dat_o  out  32  constant 0.
m_we_o  out  1  constant 0.
m_cyc_o  out  1  Wishbone cycle.
m_stb_o  out  1  Wishbone strobe.
m_dat_i  in  32  read data.
m_ack_i  in  1  acknowledge.
pix_dat  out  32  FIFO head word (show-ahead).
pix_valid  out  1  FIFO not empty.
pix_rd  in  1  pops the FIFO head when pix_valid is high; ignored when the FIFO is empty.
underrun  out  1  see Optional Feature.

Behaviour:
- Reset values: busy=0, done=0, m_cyc_o=0, m_stb_o=0, m_adr_o=0, m_cti_o=3'b000, pix_valid=0, underrun=0. Reset also empties the FIFO.
- FSM states: IDLE, WAIT, BURST.
- IDLE:
  - Accepting start latches the address pointer as {frame_base[31:2],2'b00} and latches the remaining burst count as frame_words>>burst_len_log2.
  - busy rises on the next cycle and the FSM moves to WAIT.
  - If the burst count is 0: no bus cycle is issued, done pulses on the cycle after start, busy stays 0, and the FSM stays in IDLE.
- start while busy=1 is ignored.
- WAIT:
  - Move to BURST when FIFO free space is >= 2^burst_len_log2. Free space counts in-flight beats and includes any same-cycle pix_rd pop.
  - m_cyc_o and m_stb_o assert on the cycle after the WAIT→BURST decision.
- BURST:
  - m_cyc_o and m_stb_o stay high continuously for the whole burst.
  - m_cti_o=3'b010 on every beat except the last, which uses 3'b111.
  - On each m_ack_i: m_dat_i is written into the FIFO, m_adr_o advances by 4, and the beat counter increments.
  - On the last ack: m_cyc_o and m_stb_o drop on the next cycle, and the remaining burst count decrements.
  - If the remaining count reaches 0: done pulses on the cycle after the last ack, busy falls in the same cycle, and the FSM goes to IDLE. Otherwise the FSM goes to WAIT.
  - Back-to-back bursts are allowed; a minimum one-cycle cyc gap between bursts is required so the interconnect arbiter can switch.
- The address pointer wraps modulo 2^32.
- FIFO:
  - Synchronous, registered write; the written word is visible on pix_dat/pix_valid the cycle after the ack.
  - Simultaneous write and pop leave the occupancy unchanged.
  - The FIFO can never overflow, by construction of the space check. The assertion "write while full" must never fire.
- sys_rst mid-burst: m_cyc_o and m_stb_o are 0 after the reset edge, and all state returns to its reset values. The slave is abandoned; this is acceptable because reset is system-wide.
- m_ack_i while m_cyc_o=0 is ignored.

Optional Feature:
FB_FETCH_UNDERRUN_EN
- Defined:
  - underrun is a sticky flag, set on any cycle where busy=1, pix_rd=1 and pix_valid=0.
  - It is cleared when start is accepted or on sys_rst.
  - It has no effect on the fetch.
- Undefined: underrun is tied to 0 and no extra logic is generated.

Decomposition:
- Package fb_fetch_pkg holds:
  - CTI constants: CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111.
  - FSM state encodings.
  - Default depth/burst constants.
- Sub-module fb_fetch_fifo: synchronous show-ahead FIFO parameterised by depth, exposing a level output used for the space check.

Test Plan:
- start with frame_base=32'h4000_0010, frame_words=16, zero-wait slave, pix_rd held 1 → expect:
  - 4 bursts at 0x...10, 0x...20, 0x...30, 0x...40;
  - cti 010,010,010,111 in each burst;
  - 16 words popped in order;
  - one done pulse; busy low afterwards.
- pix_rd held 0, frame_words=64, fifo depth 32 → exactly 8 bursts complete, then m_cyc_o stays 0 with the FIFO full. Enabling pix_rd resumes fetching, and all 64 words arrive in order.
- frame_words=3 (truncates to 0) → no m_cyc_o, done pulses 1 cycle after start, busy stays 0.
- Slave inserts 2 wait states per beat and a second start pulse arrives mid-frame → the second start is ignored, and the data and address sequence is unchanged.
- Assert sys_rst during beat 2 of a burst → m_cyc_o=0 and pix_valid=0 after the edge. A new start then fetches correctly from the new base.
- With FB_FETCH_UNDERRUN_EN: pix_rd=1 while the FIFO is empty and busy=1 → underrun=1 and held; the next start clears it. Without the macro, underrun is always 0.
